// File: rtl/p_i_cache_control.sv
// Instruction-cache controller: hit/miss FSM (CHECK/FETCH/FILL), 4-way tree-PLRU
// victim choice and update, per-way fill controls and wrapping hit/miss counters.
package p_i_cache_types;
    typedef enum logic [1:0] {
        no_write        = 2'b00,
        mem_write_cache = 2'b01,
        mem_write_cpu   = 2'b10
    } dataarraymux_sel_t;
endpackage

module p_i_cache_control
    import p_i_cache_types::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int CNT_W    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_read,
    output logic                               mem_resp,
    input  logic                               hit,
    input  logic [NUM_WAYS-1:0]                way_hit,
    input  logic [NUM_WAYS-1:0]                v_dataout,
    input  logic [2:0]                         LRU_array_dataout,
    output logic                               pmem_read,
    input  logic                               pmem_resp,
    output logic [NUM_WAYS-1:0]                v_array_load,
    output logic [NUM_WAYS-1:0]                v_array_datain,
    output logic [NUM_WAYS-1:0]                tag_array_load,
    output logic                               LRU_array_load,
    output logic [2:0]                         LRU_array_datain,
    output dataarraymux_sel_t [NUM_WAYS-1:0]   write_en_MUX_sel,
    output dataarraymux_sel_t [NUM_WAYS-1:0]   data_array_datain_MUX_sel,
    output logic [CNT_W-1:0]                   hit_count,
    output logic [CNT_W-1:0]                   miss_count
);
    typedef enum logic [1:0] {CHECK, FETCH, FILL} state_t;

    state_t           r_state;
    logic [1:0]       r_victim;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;

    logic [1:0] w_victim;
    logic [1:0] w_hit_way;
    logic [2:0] w_lru_next;
    logic       w_check_req;
    logic       w_fill;

    // Lowest invalid way wins; the PLRU tree only decides when every way is valid.
    always_comb begin
        w_victim = LRU_array_dataout[0] ? (LRU_array_dataout[2] ? 2'd3 : 2'd2)
                                        : (LRU_array_dataout[1] ? 2'd1 : 2'd0);
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!v_dataout[i]) w_victim = 2'(i);
    end

    always_comb begin
        w_hit_way = 2'd0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (way_hit[i]) w_hit_way = 2'(i);
    end

    // Point the tree away from the way just used.
    always_comb begin
        w_lru_next = LRU_array_dataout;
        case (w_hit_way)
            2'd0: begin w_lru_next[0] = 1'b1; w_lru_next[1] = 1'b1; end
            2'd1: begin w_lru_next[0] = 1'b1; w_lru_next[1] = 1'b0; end
            2'd2: begin w_lru_next[0] = 1'b0; w_lru_next[2] = 1'b1; end
            default: begin w_lru_next[0] = 1'b0; w_lru_next[2] = 1'b0; end
        endcase
    end

    // Gating with rst keeps every control low while reset is held.
    assign w_check_req      = rst && (r_state == CHECK) && mem_read;
    assign w_fill           = rst && (r_state == FILL);
    assign mem_resp         = w_check_req && hit;
    assign LRU_array_load   = mem_resp;
    assign LRU_array_datain = mem_resp ? w_lru_next : 3'b000;
    assign pmem_read        = rst && (r_state == FETCH);
    assign hit_count        = r_hit_count;
    assign miss_count       = r_miss_count;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        logic w_fill_way;
        assign w_fill_way                   = w_fill && (r_victim == 2'(g));
        assign tag_array_load[g]            = w_fill_way;
        assign v_array_load[g]              = w_fill_way;
        assign v_array_datain[g]            = w_fill_way;
        assign write_en_MUX_sel[g]          = w_fill_way ? mem_write_cache : no_write;
        assign data_array_datain_MUX_sel[g] = w_fill_way ? mem_write_cache : no_write;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= CHECK;
            r_victim     <= 2'd0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                CHECK: begin
                    if (mem_read) begin
                        if (hit) begin
                            r_hit_count <= r_hit_count + 1'b1;
                        end else begin
                            r_miss_count <= r_miss_count + 1'b1;
                            r_victim     <= w_victim;
                            r_state      <= FETCH;
                        end
                    end
                end
                FETCH:   if (pmem_resp) r_state <= FILL;
                FILL:    r_state <= CHECK;
                default: r_state <= CHECK;
            endcase
        end
    end
endmodule

// File: doc/p_i_cache_control.md
P_I_CACHE_CONTROL -- requirements
Module: p_i_cache_control

Interface
REQ-001 Parameter NUM_WAYS, default 4, way count; only 4 is supported.
REQ-002 Parameter CNT_W, default 32, width of the hit and miss statistics counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 mem_read  in  1  fetch request; mem_address held stable by requester until mem_resp.
REQ-006 mem_resp  out  1  request done; I-line valid on datapath dataout this cycle.
REQ-007 hit  in  1  any-way hit from the metadata/datapath block.
REQ-008 way_hit  in  4  bit i = way i hit.
REQ-009 v_dataout  in  4  bit i = valid bit of way i at the current index.
REQ-010 LRU_array_dataout  in  3  PLRU bits at the current index.
REQ-011 pmem_read  out  1  line fetch request to memory.
REQ-012 pmem_resp  in  1  memory line valid on pmem_rdata (one-cycle pulse).
REQ-013 v_array_load  out  4  bit i = load the valid bit of way i.
REQ-014 v_array_datain  out  4  bit i = valid datain for way i.
REQ-015 tag_array_load  out  4  bit i = load the tag of way i.
REQ-016 LRU_array_load  out  1  write the PLRU bits.
REQ-017 LRU_array_datain  out  3  new PLRU bits.
REQ-018 write_en_MUX_sel[0..3]  out  4 x dataarraymux_sel_t  per-way data write enable select.
REQ-019 data_array_datain_MUX_sel[0..3]  out  4 x dataarraymux_sel_t  per-way datain select.
REQ-020 hit_count, miss_count  out  CNT_W each  statistics counters.

Function
REQ-021 FSM states: CHECK, FETCH, FILL.
- CHECK is the reset state.
REQ-022 CHECK with mem_read=1 and hit=1:
- mem_resp=1 in the same cycle (0-cycle added latency).
- LRU_array_load=1 with the updated PLRU value.
- hit_count += 1.
- Remain in CHECK.
REQ-023 CHECK with mem_read=1 and hit=0:
- Latch the victim way.
- miss_count += 1.
- Go to FETCH; mem_resp=0.
REQ-024 Victim selection: lowest-index way with v_dataout=0; if all four are valid, use PLRU.
- PLRU: b0=0 selects pair {0,1}, b0=1 selects pair {2,3}.
- Within {0,1}: b1=0 selects way 0, b1=1 selects way 1.
- Within {2,3}: b2=0 selects way 2, b2=1 selects way 3.
REQ-025 PLRU update on access to way w (bits not listed keep their current value):
- w=0: b0=1, b1=1.
- w=1: b0=1, b1=0.
- w=2: b0=0, b2=1.
- w=3: b0=0, b2=0.
REQ-026 If several way_hit bits are set, the highest-index hit way drives the PLRU update.
REQ-027 FETCH: pmem_read=1 every cycle until pmem_resp=1.
- On pmem_resp, go to FILL; pmem_read drops the following cycle.
REQ-028 FILL, exactly one cycle, for the latched victim only:
- write_en_MUX_sel = mem_write_cache.
- data_array_datain_MUX_sel = mem_write_cache.
- tag_array_load=1, v_array_load=1, v_array_datain=1.
- LRU is not written.
- Go to CHECK.
REQ-029 All non-victim ways, and all ways outside FILL, use no_write for both MUX selects, with loads at 0.
REQ-030 After FILL, CHECK re-evaluates the request; the refill produces a hit there, which is counted in hit_count and updates the PLRU.
- Total miss latency = memory latency + 2 cycles.
REQ-031 If mem_read drops during FETCH, the fetch and FILL still complete; CHECK then idles with no mem_resp.
REQ-032 CHECK with mem_read=0: all control outputs are 0 / no_write.
REQ-033 Counters wrap modulo 2^CNT_W and never saturate.
REQ-034 mem_resp and pmem_read are never 1 in the same cycle.

Reset
REQ-035 While rst=0, asynchronously:
- State = CHECK.
- pmem_read=0, mem_resp=0, all loads 0, all selects no_write.
- hit_count=0, miss_count=0, victim register=0.
REQ-036 Reset asserted during FETCH or FILL abandons the transaction with no array write.
- pmem_resp arriving while in reset or after reset is ignored.
REQ-037 After rst deasserts, the first active clk edge evaluates CHECK normally.

Verification
REQ-038 Cold miss: v_dataout=0000, mem_read=1, hit=0 -> expected:
- Victim way 0; pmem_read high until pmem_resp at cycle 5.
- FILL: tag_array_load=0001, v_array_load=0001.
- Next cycle, with hit driven: mem_resp=1, LRU_array_datain=3'b011 (b0=1, b1=1, b2=0).
- miss_count=1, hit_count=1.
REQ-039 All ways valid, LRU_array_dataout=3'b101 (b0=1, b2=1), miss -> victim way 3; FILL asserts tag_array_load=1000.
REQ-040 Hit, way_hit=0100, LRU_array_dataout=3'b000 -> same-cycle mem_resp=1; LRU_array_datain=3'b100 (b0=0, b1=0, b2=1).
REQ-041 rst=0 asserted mid-FETCH, then pmem_resp pulsed -> pmem_read=0 immediately; no load in any later cycle; counters read 0.
REQ-042 mem_read dropped in FETCH -> FILL still writes the victim; no mem_resp; CHECK idle with all outputs 0.
REQ-043 Back-to-back hits over 2^CNT_W cycles with CNT_W=4 -> hit_count wraps from 15 to 0.
